rc4_ksa_engine: RTL and testbench

//  Parametrised RC4 key-scheduling engine: optional S-box identity fill (s[i]=i), then the
//  KSA shuffle j=j+s[i]+key[i mod KEY_BYTES], swap(s[i],s[j]) for i=0..DEPTH-1.

---
 rtl/rc4_pkg.sv | 33 +++
 rtl/rc4_key_sel.sv | 45 ++++
 rtl/rc4_ksa_engine.sv | 178 +++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package rc4_pkg;

  // Engine states; busy is high in all of them except S_IDLE and S_DONE.
  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_WR,
    S_RD_I,
    S_WT_I,
    S_CALC_J,
    S_RD_J,
    S_WT_J,
    S_CAP_J,
    S_WR_I,
    S_WR_J,
    S_DONE
  } ksa_state_t;

  // Widest key the byte selector can handle; keys are zero-extended to this width.
  localparam int KEY_MAX_BYTES = 32;

  // Number of S-box entries for a given word/address width.
  function automatic int KSA_DEPTH(input int data_w);
    return 1 << data_w;
  endfunction

  // Byte idx of an nbytes-long key held in the low bits of key; byte 0 is the MSB byte.
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_BYTES*8-1:0] key,
                                          input int nbytes, input int idx);
    return key[(nbytes-1-idx)*8 +: 8];
  endfunction

endpackage

// File: rtl/rc4_key_sel.sv
// Key register and cyclic byte index; presents key byte [i mod KEY_BYTES]
// without a divider by wrapping the index counter explicitly.
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic                   load,
  input  logic                   advance,
  input  logic                   clear,
  output logic [7:0]             cur_byte
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  logic [KEY_BYTES*8-1:0]     key_q;
  logic [KIDX_W-1:0]          kidx;
  logic [KEY_MAX_BYTES*8-1:0] key_ext;

  // Key is captured once per accepted start so later bus changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      key_q <= '0;
    else if (load)
      key_q <= key;
  end

  // Byte index restarts on load/abort and wraps after the last key byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      kidx <= '0;
    else if (clear || load)
      kidx <= '0;
    else if (advance)
      kidx <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
  end

  assign key_ext  = (KEY_MAX_BYTES*8)'(key_q);
  assign cur_byte = key_byte(key_ext, KEY_BYTES, int'(kidx));

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving a single-port S RAM with RAM_RD_LAT read
// latency: optional identity fill, then the j/swap shuffle over all entries.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES  = 3,
  parameter int DATA_W     = 8,
  parameter int RAM_RD_LAT = 1,
  parameter int DO_INIT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   done_ack,
  input  logic [DATA_W-1:0]      ram_q,
  output logic [DATA_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_wren,
  output logic                   busy,
  output logic                   done
);

  localparam int WCNT_W = (RAM_RD_LAT > 2) ? $clog2(RAM_RD_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RAM_RD_LAT - 2);

  ksa_state_t          state, next_state;
  logic [DATA_W-1:0]   i, j, i_data, j_data;
  logic [WCNT_W-1:0]   wcnt;
  logic [7:0]          cur_byte;
  logic [DATA_W-1:0]   kb_ext;
  logic                i_last;
  logic                key_load, key_advance;

  assign i_last      = &i;
  assign kb_ext      = DATA_W'(cur_byte);
  assign key_load    = (state == S_IDLE) && start && !abort;
  assign key_advance = (state == S_CALC_J) && !abort;

  rc4_key_sel #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sel (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .load     (key_load),
    .advance  (key_advance),
    .clear    (abort),
    .cur_byte (cur_byte)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state and RAM/status decode; abort overrides both and blocks any write.
  always_comb begin
    next_state = state;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wren   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          next_state = (DO_INIT != 0) ? S_INIT_WR : S_RD_I;
      end
      S_INIT_WR: begin
        busy      = 1'b1;
        ram_addr  = i;
        ram_wdata = i;
        ram_wren  = 1'b1;
        if (i_last)
          next_state = S_RD_I;
      end
      S_RD_I: begin
        busy       = 1'b1;
        ram_addr   = i;
        next_state = (RAM_RD_LAT == 1) ? S_CALC_J : S_WT_I;
      end
      S_WT_I: begin
        busy     = 1'b1;
        ram_addr = i;
        if (wcnt == WCNT_LAST)
          next_state = S_CALC_J;
      end
      S_CALC_J: begin
        busy       = 1'b1;
        ram_addr   = i;
        next_state = S_RD_J;
      end
      S_RD_J: begin
        busy       = 1'b1;
        ram_addr   = j;
        next_state = (RAM_RD_LAT == 1) ? S_CAP_J : S_WT_J;
      end
      S_WT_J: begin
        busy     = 1'b1;
        ram_addr = j;
        if (wcnt == WCNT_LAST)
          next_state = S_CAP_J;
      end
      S_CAP_J: begin
        busy       = 1'b1;
        ram_addr   = j;
        next_state = S_WR_I;
      end
      S_WR_I: begin
        busy       = 1'b1;
        ram_addr   = i;
        ram_wdata  = j_data;
        ram_wren   = 1'b1;
        next_state = S_WR_J;
      end
      S_WR_J: begin
        busy       = 1'b1;
        ram_addr   = j;
        ram_wdata  = i_data;
        ram_wren   = 1'b1;
        next_state = i_last ? S_DONE : S_RD_I;
      end
      S_DONE: begin
        done = 1'b1;
        if (done_ack)
          next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort) begin
      next_state = S_IDLE;
      ram_wren   = 1'b0;
    end
  end

  // Index, accumulator, swap operands and read-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i      <= '0;
      j      <= '0;
      i_data <= '0;
      j_data <= '0;
      wcnt   <= '0;
    end else if (abort) begin
      i    <= '0;
      j    <= '0;
      wcnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            i <= '0;
            j <= '0;
          end
        end
        S_INIT_WR: i <= i + 1'b1;
        S_RD_I, S_RD_J: wcnt <= '0;
        S_WT_I, S_WT_J: wcnt <= wcnt + 1'b1;
        S_CALC_J: begin
          i_data <= ram_q;
          j      <= j + ram_q + kb_ext;
        end
        S_CAP_J: j_data <= ram_q;
        S_WR_J: begin
          if (!i_last)
            i <= i + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Directed bench for rc4_ksa_engine: three configurations with behavioural S RAMs
// and a software KSA reference.
module tb_rc4_ksa_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic done_ack = 1'b0;
  logic preload_c = 1'b0;

  always #5 clk = ~clk;

  // Instance A: DATA_W=2, KEY_BYTES=1, LAT=1, DO_INIT=1
  logic [7:0] key_a = '0;
  logic       start_a = 1'b0;
  logic [1:0] q_a, addr_a, wdata_a, qa1;
  logic       wren_a, busy_a, done_a;
  logic [1:0] mem_a [0:3];

  // Instance B: DATA_W=8, KEY_BYTES=3, LAT=2, DO_INIT=1
  logic [23:0] key_b = '0;
  logic        start_b = 1'b0;
  logic [7:0]  q_b, addr_b, wdata_b, qb1, qb2;
  logic        wren_b, busy_b, done_b;
  logic [7:0]  mem_b [0:255];

  // Instance C: DATA_W=4, KEY_BYTES=5, LAT=3, DO_INIT=0
  logic [39:0] key_c = '0;
  logic        start_c = 1'b0;
  logic [3:0]  q_c, addr_c, wdata_c, qc1, qc2, qc3;
  logic        wren_c, busy_c, done_c;
  logic [3:0]  mem_c [0:15];

  rc4_ksa_engine #(.KEY_BYTES(1), .DATA_W(2), .RAM_RD_LAT(1), .DO_INIT(1)) dut_a (
    .clk(clk), .rst(rst), .key(key_a), .start(start_a), .abort(abort),
    .done_ack(done_ack), .ram_q(q_a), .ram_addr(addr_a), .ram_wdata(wdata_a),
    .ram_wren(wren_a), .busy(busy_a), .done(done_a));

  rc4_ksa_engine #(.KEY_BYTES(3), .DATA_W(8), .RAM_RD_LAT(2), .DO_INIT(1)) dut_b (
    .clk(clk), .rst(rst), .key(key_b), .start(start_b), .abort(abort),
    .done_ack(done_ack), .ram_q(q_b), .ram_addr(addr_b), .ram_wdata(wdata_b),
    .ram_wren(wren_b), .busy(busy_b), .done(done_b));

  rc4_ksa_engine #(.KEY_BYTES(5), .DATA_W(4), .RAM_RD_LAT(3), .DO_INIT(0)) dut_c (
    .clk(clk), .rst(rst), .key(key_c), .start(start_c), .abort(abort),
    .done_ack(done_ack), .ram_q(q_c), .ram_addr(addr_c), .ram_wdata(wdata_c),
    .ram_wren(wren_c), .busy(busy_c), .done(done_c));

  // Single-port RAMs with read latency pipelines.
  always @(posedge clk) begin
    if (wren_a) mem_a[addr_a] <= wdata_a;
    qa1 <= mem_a[addr_a];
  end
  assign q_a = qa1;

  always @(posedge clk) begin
    if (wren_b) mem_b[addr_b] <= wdata_b;
    qb1 <= mem_b[addr_b];
    qb2 <= qb1;
  end
  assign q_b = qb2;

  always @(posedge clk) begin
    if (preload_c) begin
      for (int k = 0; k < 16; k++) mem_c[k] <= 4'(k);
    end else if (wren_c) begin
      mem_c[addr_c] <= wdata_c;
    end
    qc1 <= mem_c[addr_c];
    qc2 <= qc1;
    qc3 <= qc2;
  end
  assign q_c = qc3;

  int checks = 0;
  int passed = 0;
  int gold [0:255];
  int n, wr, n2, wr2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_wren(input int which);
    case (which)
      0: return wren_a;
      1: return wren_b;
      default: return wren_c;
    endcase
  endfunction

  // Software KSA over an identity S-box of 2**dw entries.
  task automatic compute_gold(input int dw, input int kbytes, input logic [63:0] key);
    int depth, mask, j, t, kb;
    depth = 1 << dw;
    mask  = depth - 1;
    for (int k = 0; k < depth; k++) gold[k] = k;
    j = 0;
    for (int i = 0; i < depth; i++) begin
      kb = int'((key >> (8 * (kbytes - 1 - (i % kbytes)))) & 64'hFF);
      j = (j + gold[i] + kb) & mask;
      t = gold[i];
      gold[i] = gold[j];
      gold[j] = t;
    end
  endtask

  task automatic check_s(input int which, input int depth, input string tag);
    int mism, obs;
    mism = 0;
    for (int k = 0; k < depth; k++) begin
      case (which)
        0: obs = int'(mem_a[k[1:0]]);
        1: obs = int'(mem_b[k[7:0]]);
        default: obs = int'(mem_c[k[3:0]]);
      endcase
      if (obs != gold[k]) mism++;
    end
    chk(tag, 64'(mism), 64'd0);
  endtask

  // Present start with a key for one edge; returns sampling cycle 1 of the run.
  task automatic start_op(input int which, input logic [63:0] k);
    case (which)
      0: begin key_a = k[7:0];  start_a = 1'b1; end
      1: begin key_b = k[23:0]; start_b = 1'b1; end
      default: begin key_c = k[39:0]; start_c = 1'b1; end
    endcase
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Count edges until done and writes seen on the way, within a cycle budget.
  task automatic wait_done(input int which, input int budget, output int cyc, output int writes);
    cyc = 0;
    writes = get_wren(which) ? 1 : 0;
    while (!get_done(which) && cyc < budget) begin
      tick();
      cyc++;
      if (get_wren(which)) writes++;
    end
  endtask

  task automatic ack();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_wren_a", 64'(wren_a), 64'd0);
    chk("rst_addr_b", 64'(addr_b), 64'd0);
    chk("rst_wdata_b", 64'(wdata_b), 64'd0);
    chk("rst_busy_c", 64'(busy_c), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // A: key 0, small S-box; start pulsed mid-run with a different key is ignored
    start_op(0, 64'h00);
    chk("a_busy_run", 64'(busy_a), 64'd1);
    for (int k = 0; k < 5; k++) tick();
    key_a = 8'hFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 200, n, wr);
    chk("a_cycles", 64'(n + 6), 64'd28);
    chk("a_s0", 64'(mem_a[0]), 64'd0);
    chk("a_s1", 64'(mem_a[1]), 64'd2);
    chk("a_s2", 64'(mem_a[2]), 64'd3);
    chk("a_s3", 64'(mem_a[3]), 64'd1);
    chk("a_done_busy", 64'(busy_a), 64'd0);
    tick();
    chk("a_done_hold", 64'(done_a), 64'd1);

    // DONE with done_ack and start together: back to IDLE, start dropped
    done_ack = 1'b1;
    start_a = 1'b1;
    tick();
    done_ack = 1'b0;
    start_a = 1'b0;
    chk("a_ack_done", 64'(done_a), 64'd0);
    chk("a_ack_busy", 64'(busy_a), 64'd0);
    tick();
    chk("a_ack_idle", 64'(busy_a), 64'd0);

    // B: 256-entry S-box, 3-byte key, read latency 2
    compute_gold(8, 3, 64'h4B6579);
    start_op(1, 64'h4B6579);
    wait_done(1, 5000, n, wr);
    chk("b_cycles", 64'(n), 64'd2304);
    check_s(1, 256, "b_sbox");
    chk("b_writes", 64'(wr), 64'd768);
    ack();
    chk("b_ack_done", 64'(done_b), 64'd0);

    // C: no identity fill, RAM preloaded, 5-byte key truncated to 4-bit words
    preload_c = 1'b1;
    tick();
    preload_c = 1'b0;
    compute_gold(4, 5, 64'hA1B2C3D4E5);
    start_op(2, 64'hA1B2C3D4E5);
    wait_done(2, 1000, n, wr);
    chk("c_cycles", 64'(n), 64'd160);
    chk("c_writes", 64'(wr), 64'd32);
    check_s(2, 16, "c_sbox");
    ack();

    // Abort landing on the first WR_I of A
    start_op(0, 64'h00);
    for (int k = 0; k < 8; k++) tick();
    chk("abort_pre_wren", 64'(wren_a), 64'd1);
    abort = 1'b1;
    #1;
    chk("abort_wren", 64'(wren_a), 64'd0);
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_done", 64'(done_a), 64'd0);
    tick();
    compute_gold(2, 1, 64'h00);
    start_op(0, 64'h00);
    wait_done(0, 200, n, wr);
    chk("abort_restart_cycles", 64'(n), 64'd28);
    check_s(0, 4, "abort_restart_sbox");
    ack();

    // Asynchronous reset mid-shuffle, then a fresh run with a truncated key byte
    start_op(0, 64'h5A);
    for (int k = 0; k < 10; k++) tick();
    chk("rst_mid_busy_pre", 64'(busy_a), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy_a), 64'd0);
    chk("rst_mid_addr", 64'(addr_a), 64'd0);
    chk("rst_mid_wren", 64'(wren_a), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_idle", 64'(busy_a), 64'd0);
    compute_gold(2, 1, 64'h5A);
    start_op(0, 64'h5A);
    wait_done(0, 200, n2, wr2);
    chk("rst_rerun_cycles", 64'(n2), 64'd28);
    check_s(0, 4, "rst_rerun_sbox");
    ack();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
